qsys_irq_aggregator: RTL and testbench

//  Avalon-MM slave that collects the timer's irq and up to 15 other interrupt sources into one
//  CPU irq line. Latches source edges into a pending register, applies a mask, and reports the

---
 rtl/qsys_irq_aggregator.sv | 176 +++++++++++++++++
 tb/tb_qsys_irq_aggregator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_irq_aggregator.sv
// qsys_irq_aggregator
//  Avalon-MM interrupt aggregator: edge/level latched pending register,
//  enable mask, lowest-index priority report and a registered CPU irq.
//  src_irq[0] is the system timer interrupt.
//  Optional overrun counter at address 4 is built when the macro
//  IRQ_AGG_OVERRUN_CNT_EN is defined; otherwise address 4 reads 0.
module qsys_irq_aggregator #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_SRC     = 3'd3;
    localparam logic [2:0] ADDR_OVR     = 3'd4;

    // State
    logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
    logic [NUM_SRC-1:0] pending_q,  pending_d;
    logic [NUM_SRC-1:0] mask_q,     mask_d;
    logic [NUM_SRC-1:0] mode_q,     mode_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_q,      irq_d;

    // Combinational helpers
    logic               wr_s;
    logic [NUM_SRC-1:0] src_edge_s;
    logic [NUM_SRC-1:0] w1c_s;
    logic [NUM_SRC-1:0] active_s;
    logic               src_valid_s;
    logic [3:0]         src_idx_s;
    logic [15:0]        rd_mux_s;

`ifdef IRQ_AGG_OVERRUN_CNT_EN
    logic [7:0]         ovr_cnt_q, ovr_cnt_d;
    logic               ovr_hit_s;
`endif

    // Bus strobe, rising-edge detect and write-1-to-clear vector
    always_comb begin
        wr_s       = chipselect & ~write_n;
        src_edge_s = src_irq & ~src_prev_q;
        if (wr_s && (address == ADDR_PENDING)) begin
            w1c_s = writedata[NUM_SRC-1:0];
        end else begin
            w1c_s = {NUM_SRC{1'b0}};
        end
    end

    // Pending update: level bits follow the source, edge bits are sticky
    // and a new edge beats a simultaneous clear
    always_comb begin
        pending_d  = pending_q;
        src_prev_d = src_irq;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mode_q[i]) begin
                pending_d[i] = src_edge_s[i] | (pending_q[i] & ~w1c_s[i]);
            end else begin
                pending_d[i] = src_irq[i];
            end
        end
    end

    // MASK and MODE register writes
    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (wr_s) begin
            case (address)
                ADDR_MASK: mask_d = writedata[NUM_SRC-1:0];
                ADDR_MODE: mode_d = writedata[NUM_SRC-1:0];
                default: begin
                    mask_d = mask_q;
                    mode_d = mode_q;
                end
            endcase
        end else begin
            mask_d = mask_q;
            mode_d = mode_q;
        end
    end

    // Lowest-index enabled pending source (scan downwards so the lowest wins)
    always_comb begin
        active_s    = pending_q & mask_q;
        src_valid_s = |active_s;
        src_idx_s   = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            src_idx_s = active_s[i] ? 4'(i) : src_idx_s;
        end
    end

`ifdef IRQ_AGG_OVERRUN_CNT_EN
    // Overrun counter: edge on an already-pending edge-mode source, saturating,
    // a write to its address clears and takes precedence
    always_comb begin
        ovr_hit_s = |(src_edge_s & mode_q & pending_q);
        if (wr_s && (address == ADDR_OVR)) begin
            ovr_cnt_d = 8'h00;
        end else if (ovr_hit_s && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'h01;
        end else begin
            ovr_cnt_d = ovr_cnt_q;
        end
    end
`endif

    // Read mux on current (pre-write) register contents
    always_comb begin
        rd_mux_s = 16'h0000;
        case (address)
            ADDR_PENDING: rd_mux_s[NUM_SRC-1:0] = pending_q;
            ADDR_MASK:    rd_mux_s[NUM_SRC-1:0] = mask_q;
            ADDR_MODE:    rd_mux_s[NUM_SRC-1:0] = mode_q;
            ADDR_SRC: begin
                if (src_valid_s) begin
                    rd_mux_s = {1'b1, 11'h000, src_idx_s};
                end else begin
                    rd_mux_s = 16'h0000;
                end
            end
`ifdef IRQ_AGG_OVERRUN_CNT_EN
            ADDR_OVR:     rd_mux_s = {8'h00, ovr_cnt_q};
`else
            ADDR_OVR:     rd_mux_s = 16'h0000;
`endif
            default:      rd_mux_s = 16'h0000;
        endcase
        readdata_d = rd_mux_s;
        irq_d      = src_valid_s;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_prev_q <= {NUM_SRC{1'b0}};
            pending_q  <= {NUM_SRC{1'b0}};
            mask_q     <= {NUM_SRC{1'b0}};
            mode_q     <= {NUM_SRC{1'b0}};
            readdata_q <= 16'h0000;
            irq_q      <= 1'b0;
        end else begin
            src_prev_q <= src_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

`ifdef IRQ_AGG_OVERRUN_CNT_EN
    // Overrun counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_cnt_q <= 8'h00;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end
`endif

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_qsys_irq_aggregator.sv
// Testbench for qsys_irq_aggregator: directed vectors with literal
// expectations plus a per-cycle behavioural model of the register map.
module tb_qsys_irq_aggregator;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] src_irq = '0;
    logic [2:0]   address = 3'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [15:0]  writedata = 16'h0000;
    logic [15:0]  readdata;
    logic         irq;

    int errors = 0;
    int checks = 0;

    qsys_irq_aggregator #(.NUM_SRC(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .src_irq    (src_irq),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit   m_prev[N];
    bit   m_pend[N];
    bit   m_mask[N];
    bit   m_mode[N];
    int   m_ovr;
    logic [15:0] m_rd;
    logic        m_irq;

    function automatic logic [15:0] m_read(input int a);
        logic [15:0] v;
        v = 16'h0000;
        case (a)
            0: for (int i = 0; i < N; i++) v[i] = m_pend[i];
            1: for (int i = 0; i < N; i++) v[i] = m_mask[i];
            2: for (int i = 0; i < N; i++) v[i] = m_mode[i];
            3: begin
                for (int i = N - 1; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) v = 16'h8000 + 16'(i);
            end
`ifdef IRQ_AGG_OVERRUN_CNT_EN
            4: v = 16'(m_ovr);
`endif
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    bit np[N];
    bit mwr;
    bit m_edge;
    bit m_hit;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 1'b0; m_pend[i] = 1'b0; m_mask[i] = 1'b0; m_mode[i] = 1'b0;
            end
            m_ovr = 0; m_rd = 16'h0000; m_irq = 1'b0;
        end else begin
            mwr   = chipselect && !write_n;
            m_rd  = m_read(int'(address));
            m_irq = 1'b0;
            m_hit = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && m_mask[i]) m_irq = 1'b1;
                m_edge = src_irq[i] && !m_prev[i];
                if (!m_mode[i])                                  np[i] = src_irq[i];
                else if (m_edge)                                 np[i] = 1'b1;
                else if (mwr && address == 3'd0 && writedata[i]) np[i] = 1'b0;
                else                                             np[i] = m_pend[i];
                if (m_mode[i] && m_edge && m_pend[i]) m_hit = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                m_pend[i] = np[i];
                m_prev[i] = src_irq[i];
                if (mwr && address == 3'd1) m_mask[i] = writedata[i];
                if (mwr && address == 3'd2) m_mode[i] = writedata[i];
            end
            if (mwr && address == 3'd4) m_ovr = 0;
            else if (m_hit && m_ovr < 255) m_ovr = m_ovr + 1;
        end
        #1;
        chk("model_readdata", readdata, m_rd);
        chk("model_irq", {15'h0000, irq}, {15'h0000, m_irq});
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [15:0] exp, input string name);
        address = a;
        tick();
        chk(name, readdata, exp);
    endtask

    initial begin
        tick(); tick();
        chk("reset_readdata", readdata, 16'h0000);
        chk("reset_irq", {15'h0000, irq}, 16'h0000);
        reset_n = 1'b1;
        tick();

        // 1: single edge on the timer source
        wr(3'd2, 16'h000F);
        wr(3'd1, 16'h0001);
        src_irq = 4'b0001; tick();
        chk("t1_irq_cycle1", {15'h0000, irq}, 16'h0000);
        src_irq = 4'b0000; tick();
        chk("t1_irq_cycle2", {15'h0000, irq}, 16'h0001);
        rd_chk(3'd0, 16'h0001, "t1_pending");
        rd_chk(3'd3, 16'h8000, "t1_src");
        wr(3'd0, 16'h0001);
        chk("t1_irq_after_w1c", {15'h0000, irq}, 16'h0001);
        tick();
        chk("t1_irq_cleared", {15'h0000, irq}, 16'h0000);

        // 2: priority among enabled pending sources
        src_irq = 4'b1010; tick();
        src_irq = 4'b0000; tick();
        wr(3'd1, 16'h000A);
        rd_chk(3'd3, 16'h8001, "t2_src_1");
        wr(3'd0, 16'h0002);
        rd_chk(3'd3, 16'h8003, "t2_src_3");
        wr(3'd0, 16'h000F);
        rd_chk(3'd3, 16'h0000, "t2_src_none");

        // 3: edge beats a simultaneous clear
        src_irq = 4'b0100;
        wr(3'd0, 16'h0004);
        src_irq = 4'b0000;
        rd_chk(3'd0, 16'h0004, "t3_set_wins");
        wr(3'd0, 16'h000F);
        rd_chk(3'd0, 16'h0000, "t3_cleared");

        // 4: level mode on source 1
        wr(3'd2, 16'h000D);
        wr(3'd1, 16'h0002);
        src_irq = 4'b0010; tick();
        chk("t4_irq_c1", {15'h0000, irq}, 16'h0000);
        tick();
        chk("t4_irq_c2", {15'h0000, irq}, 16'h0001);
        wr(3'd0, 16'h0002);
        chk("t4_irq_c3", {15'h0000, irq}, 16'h0001);
        tick();
        chk("t4_irq_c4", {15'h0000, irq}, 16'h0001);
        tick();
        chk("t4_irq_c5", {15'h0000, irq}, 16'h0001);
        src_irq = 4'b0000; tick();
        chk("t4_irq_c6", {15'h0000, irq}, 16'h0001);
        tick();
        chk("t4_irq_off", {15'h0000, irq}, 16'h0000);

        // 5: overrun counter, 300 edges on source 0 with no clear
        for (int k = 0; k < 300; k++) begin
            src_irq = 4'b0001; tick();
            src_irq = 4'b0000; tick();
        end
`ifdef IRQ_AGG_OVERRUN_CNT_EN
        rd_chk(3'd4, 16'h00FF, "t5_ovr_sat");
`else
        rd_chk(3'd4, 16'h0000, "t5_ovr_absent");
`endif
        wr(3'd4, 16'h0000);
        rd_chk(3'd4, 16'h0000, "t5_ovr_cleared");
        rd_chk(3'd5, 16'h0000, "t5_addr5");

        // 6: async reset mid-pulse
        wr(3'd2, 16'h000F);
        wr(3'd1, 16'h000F);
        src_irq = 4'b1111; tick();
        tick();
        address = 3'd0; tick();
        chk("t6_pending_pre", readdata, 16'h000F);
        chk("t6_irq_pre", {15'h0000, irq}, 16'h0001);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rd_async", readdata, 16'h0000);
        chk("t6_irq_async", {15'h0000, irq}, 16'h0000);
        tick();
        rd_chk(3'd1, 16'h0000, "t6_mask_in_reset");
        rd_chk(3'd0, 16'h0000, "t6_pend_in_reset");
        reset_n = 1'b1;
        tick();
        tick();
        chk("t6_pend_after_release", readdata, 16'h000F);
        rd_chk(3'd1, 16'h0000, "t6_mask_after_release");
        src_irq = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
